// File: rtl/router_pkg.sv
// Shared definitions for the router packet path: field widths, header layout,
// transmit FSM states and small helpers used by both TX and RX sides.
package router_pkg;

   localparam int LEN_W     = 6;
   localparam int ADDR_W    = 2;
   localparam int NUM_PORTS = 3;
   localparam int BUF_DEPTH = 2 ** LEN_W;

   // Header byte is {len, addr}: length in the upper bits, destination in the lower bits.
   localparam int HDR_ADDR_LSB = 0;
   localparam int HDR_LEN_LSB  = ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT,
      HDR,
      PAY,
      PAR,
      GAP
   } tx_state_e;

   function automatic logic [7:0] make_header(input logic [LEN_W-1:0]  len,
                                              input logic [ADDR_W-1:0] addr);
      logic [7:0] hdr;
      hdr = '0;
      hdr[HDR_LEN_LSB  +: LEN_W]  = len;
      hdr[HDR_ADDR_LSB +: ADDR_W] = addr;
      return hdr;
   endfunction

   function automatic logic addr_is_legal(input logic [ADDR_W-1:0] addr);
      return int'(addr) < NUM_PORTS;
   endfunction

endpackage

// File: rtl/router_tx_buf.sv
// 64x8 packet buffer with auto-incrementing write/read pointers and a common clear.
// The read port is registered and always presents the entry at the current read pointer.
module router_tx_buf
   import router_pkg::*;
(
   input  logic             clock,
   input  logic             resetn,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             rd_adv,
   output logic [LEN_W-1:0] wr_ptr,
   output logic [LEN_W-1:0] rd_ptr,
   output logic [7:0]       rd_data
);

   logic [7:0]       mem [BUF_DEPTH];
   logic [LEN_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [LEN_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [7:0]       rd_data_reg;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (clr) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + LEN_W'(1);
         end
         if (rd_adv) begin
            rd_ptr_next = rd_ptr_reg + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Reading at the next pointer keeps rd_data aligned with rd_ptr without a bubble.
   always_ff @(posedge clock) begin
      if (wr_en && !clr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
      rd_data_reg <= mem[rd_ptr_next];
   end

   assign wr_ptr  = wr_ptr_reg;
   assign rd_ptr  = rd_ptr_reg;
   assign rd_data = rd_data_reg;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the router: buffers a whole payload, then streams header,
// payload and parity gap-free while honouring the router's busy back-pressure.
module router_pkt_tx
   import router_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_corrupt,
   input  logic              pl_valid,
   output logic              pl_ready,
   input  logic [7:0]        pl_data,
   input  logic              busy,
   output logic              pkt_valid,
   output logic [7:0]        tx_data,
   output logic              pkt_done,
   output logic              bad_cmd,
   output logic [CNT_W-1:0]  pkt_count
);

   tx_state_e         state_reg, state_next;
   logic [LEN_W-1:0]  len_reg, len_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              corrupt_reg, corrupt_next;
   logic [7:0]        parity_reg, parity_next;
   logic              pkt_valid_reg, pkt_valid_next;
   logic [7:0]        tx_data_reg, tx_data_next;
   logic              pkt_done_reg, pkt_done_next;
   logic              bad_cmd_reg, bad_cmd_next;
   logic [CNT_W-1:0]  pkt_count_reg, pkt_count_next;

   logic              buf_clr, buf_wr, buf_adv;
   logic [LEN_W-1:0]  buf_wr_ptr, buf_rd_ptr;
   logic [7:0]        buf_rd_data;
   logic [LEN_W-1:0]  last_idx;

   router_tx_buf u_buf (
      .clock   (clock),
      .resetn  (resetn),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_data (pl_data),
      .rd_adv  (buf_adv),
      .wr_ptr  (buf_wr_ptr),
      .rd_ptr  (buf_rd_ptr),
      .rd_data (buf_rd_data)
   );

   assign last_idx = len_reg - LEN_W'(1);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         addr_reg      <= '0;
         corrupt_reg   <= 1'b0;
         parity_reg    <= '0;
         pkt_valid_reg <= 1'b0;
         tx_data_reg   <= '0;
         pkt_done_reg  <= 1'b0;
         bad_cmd_reg   <= 1'b0;
         pkt_count_reg <= '0;
      end else begin
         state_reg     <= state_next;
         len_reg       <= len_next;
         addr_reg      <= addr_next;
         corrupt_reg   <= corrupt_next;
         parity_reg    <= parity_next;
         pkt_valid_reg <= pkt_valid_next;
         tx_data_reg   <= tx_data_next;
         pkt_done_reg  <= pkt_done_next;
         bad_cmd_reg   <= bad_cmd_next;
         pkt_count_reg <= pkt_count_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      len_next       = len_reg;
      addr_next      = addr_reg;
      corrupt_next   = corrupt_reg;
      parity_next    = parity_reg;
      pkt_done_next  = 1'b0;
      bad_cmd_next   = 1'b0;
      pkt_count_next = pkt_count_reg;
      buf_clr        = 1'b0;
      buf_wr         = 1'b0;
      buf_adv        = 1'b0;
      pkt_valid_next = 1'b0;
      tx_data_next   = '0;

      unique case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               len_next     = cmd_len;
               addr_next    = cmd_addr;
               corrupt_next = cmd_corrupt;
               parity_next  = make_header(cmd_len, cmd_addr);
               buf_clr      = 1'b1;
               if (!addr_is_legal(cmd_addr)) begin
                  bad_cmd_next = 1'b1;
               end else if (cmd_len == '0) begin
                  state_next = WAIT;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (pl_valid) begin
               buf_wr      = 1'b1;
               parity_next = parity_reg ^ pl_data;
               if (buf_wr_ptr == last_idx) begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (!busy) begin
               state_next = HDR;
            end
         end
         HDR: begin
            if (!busy) begin
               state_next = (len_reg == '0) ? PAR : PAY;
            end
         end
         PAY: begin
            if (!busy) begin
               buf_adv = 1'b1;
               if (buf_rd_ptr == last_idx) begin
                  state_next = PAR;
               end
            end
         end
         PAR: begin
            if (!busy) begin
               pkt_done_next  = 1'b1;
               pkt_count_next = pkt_count_reg + CNT_W'(1);
               state_next     = GAP;
            end
         end
         GAP: begin
            if (!busy) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Outputs are computed for the state being entered so they appear registered.
      pkt_valid_next = (state_next == HDR) || (state_next == PAY);
      case (state_next)
         HDR:     tx_data_next = make_header(len_next, addr_next);
         PAR:     tx_data_next = corrupt_next ? ~parity_next : parity_next;
         default: tx_data_next = 8'h00;
      endcase
   end

   // Payload bytes come straight from the buffer's registered read port.
   assign tx_data   = (state_reg == PAY) ? buf_rd_data : tx_data_reg;
   assign pkt_valid = pkt_valid_reg;
   assign cmd_ready = (state_reg == IDLE);
   assign pl_ready  = (state_reg == LOAD);
   assign pkt_done  = pkt_done_reg;
   assign bad_cmd   = bad_cmd_reg;
   assign pkt_count = pkt_count_reg;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Upstream packet source for router_top; its outputs connect directly to the router's pkt_valid and data_in inputs.
- Accepts a packet command (length, destination address, corrupt flag) and stages the full payload in a local buffer.
- Serialises header, payload and parity onto the router input, obeying the router's busy back-pressure.
- Converts bursty producers into the gap-free byte stream the router's FSM requires.

Parameters:
LEN_W, 6, payload length field width; maximum payload is 2**LEN_W-1 = 63 bytes
ADDR_W, 2, destination address field width; legal values are 0..NUM_PORTS-1
NUM_PORTS, 3, number of router output ports
CNT_W, 16, width of the sent-packet counter

Ports:
clock  in  1  single clock, all logic on rising edge
resetn  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_len  in  LEN_W  payload byte count, 0..63
cmd_addr  in  ADDR_W  destination port
cmd_corrupt  in  1  send inverted parity
pl_valid  in  1  payload byte offered
pl_ready  out  1  payload byte accepted when pl_valid && pl_ready
pl_data  in  8  payload byte
busy  in  1  router busy; the current byte must be held
pkt_valid  out  1  to router pkt_valid
tx_data  out  8  to router data_in
pkt_done  out  1  one-cycle pulse when the parity byte is taken
bad_cmd  out  1  one-cycle pulse when a command with cmd_addr >= NUM_PORTS is accepted
pkt_count  out  CNT_W  packets sent; wraps modulo 2**CNT_W

Behaviour:
- Reset values:
  - state IDLE
  - pkt_valid, tx_data, pkt_done, bad_cmd, pl_ready = 0
  - cmd_ready = 1; pkt_count = 0
  - buffer contents don't-care
- Reset mid-operation aborts the packet on the next edge; no parity byte is sent.
- Byte taken: a byte is "taken" at any rising edge in HDR/PAY/PAR with busy=0. While busy=1, pkt_valid and tx_data hold their values.
- Header byte = {len, addr}. Parity = XOR of header and all payload bytes. With cmd_corrupt=1 the sent parity byte is ~parity.
- IDLE:
  - cmd_ready=1.
  - On command accept, latch len/addr/corrupt.
  - If addr >= NUM_PORTS: pulse bad_cmd the next cycle, stay IDLE, consume no payload.
  - Else if len=0 go WAIT; otherwise go LOAD.
- LOAD:
  - pl_ready=1; each accepted byte is written to the buffer and XORed into parity.
  - After the len-th byte go WAIT.
  - pl_ready=0 in every other state.
- WAIT: pkt_valid=0; go HDR at the first edge with busy=0.
- HDR: pkt_valid=1, tx_data=header. When taken, go PAY (len>0) or PAR (len=0).
- PAY:
  - pkt_valid=1, tx_data=buf[rd_ptr].
  - When taken, rd_ptr++; after the len-th byte go PAR.
  - Bytes are sent in acceptance order; no byte is skipped or duplicated across stalls.
- PAR:
  - pkt_valid=0, tx_data=parity byte.
  - When taken: pulse pkt_done, pkt_count++, go GAP.
- GAP:
  - pkt_valid=0, tx_data=0 for at least one cycle; stay while busy=1.
  - Go IDLE when busy=0.
  - Guarantees the router sees at least one idle cycle between packets.
- Outputs are registered; tx_data changes only on rising edges.
- Minimum packet time with busy=0: len+2 cycles from HDR entry to GAP.

Decomposition:
- Shared package router_pkg: LEN_W, ADDR_W, NUM_PORTS, the header field positions ({len, addr} ordering) and the state enum (IDLE, LOAD, WAIT, HDR, PAY, PAR, GAP).
- One sub-module, router_tx_buf: a 64x8 register file with write pointer, read pointer and pointer clear. It is reused by the downstream receive side.

Test Plan:
- cmd len=14, addr=0, corrupt=0; payload 0x01..0x0E; busy=0 -> tx_data 0x38, then 0x01..0x0E with pkt_valid=1 for 15 cycles; then pkt_valid=0, tx_data=0x37; pkt_done pulse; pkt_count=1.
- Same command with corrupt=1 -> parity byte 0xC8; the preceding 15 bytes are identical.
- Same packet with busy=1 for 3 cycles while tx_data=0x05 -> 0x05 held 4 cycles; next byte 0x06; total pkt_valid-high cycles = 18.
- cmd len=0, addr=2 -> header 0x02 for one cycle with pkt_valid=1, then parity 0x02 with pkt_valid=0; pl_ready never asserted.
- cmd addr=3 -> bad_cmd pulse, pkt_valid stays 0, pl_ready stays 0, cmd_ready=1 next cycle; busy=1 at WAIT entry delays the header until busy falls.
- resetn=0 for one cycle while in PAY -> the next cycle shows pkt_valid=0, tx_data=0, cmd_ready=1, pkt_count=0; no pkt_done pulse.
